// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit controller and its arbiter.
// Header byte layout: {HDR_NIBBLE, requester id}.
package uart_ctrl_pkg;

  localparam int MAX_REQ = 16;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

  // Highest set bit wins; callers only pass one-hot or zero vectors.
  function automatic logic [3:0] onehot_to_id(input logic [MAX_REQ-1:0] oh);
    logic [3:0] id;
    id = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) id = 4'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: searches from (last_grant+1) mod NUM_REQ.
// Zero latency, no state; grant is one-hot or all-zero when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic [4:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = 5'(last_grant) + 5'(i);
      if (idx >= 5'(NUM_REQ)) idx = idx - 5'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (idx == 5'(j))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams, one whole packet per grant.
// Trigger is registered (one cycle after handshake); requesters only see ready in FETCH while granted.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int HEADER_EN = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  input  logic                 tx_busy_in,
  output logic                 tx_trigger_out,
  output logic [7:0]           tx_data_out,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 active_out
);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be within 1..16");
  end

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [3:0]           last_grant_q, last_grant_d;
  logic                 last_q, last_d;
  logic                 trig_q, trig_d;
  logic [7:0]           data_q, data_d;
  logic                 active_q, active_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [3:0]           arb_id;
  logic [3:0]           cur_id;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic                 fetch_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid_in),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  assign arb_id = onehot_to_id(MAX_REQ'(arb_grant));
  assign cur_id = onehot_to_id(MAX_REQ'(grant_q));

  // Byte and last flag of the current owner.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_q[j]) begin
        sel_data = req_data_in[8*j +: 8];
        sel_last = req_last_in[j];
      end
    end
  end

  assign fetch_hs = (state_q == FETCH) && |(req_valid_in & grant_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    trig_d       = 1'b0;
    data_d       = data_q;
    active_d     = active_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_in && !tx_busy_in) begin
          grant_d  = arb_grant;
          active_d = 1'b1;
          if (HEADER_EN != 0) begin
            data_d  = {HDR_NIBBLE, arb_id};
            trig_d  = 1'b1;
            last_d  = 1'b0;
            state_d = WAIT_START;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (fetch_hs) begin
          data_d  = sel_data;
          last_d  = sel_last;
          trig_d  = 1'b1;
          state_d = WAIT_START;
        end
      end
      // Busy rises one cycle after the trigger; wait for it before looking for the fall.
      WAIT_START: begin
        if (tx_busy_in) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy_in) begin
          if (last_q) begin
            last_grant_d = cur_id;
            grant_d      = '0;
            active_d     = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 4'(NUM_REQ - 1);
      last_q       <= 1'b0;
      trig_q       <= 1'b0;
      data_q       <= 8'h00;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      trig_q       <= trig_d;
      data_q       <= data_d;
      active_q     <= active_d;
    end
  end

  assign req_ready_out  = (state_q == FETCH) ? grant_q : '0;
  assign tx_trigger_out = trig_q;
  assign tx_data_out    = data_q;
  assign grant_out      = grant_q;
  assign active_out     = active_q;

  a_grant_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in) $onehot0(grant_q));
  a_ready_owner:  assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                   (req_ready_out & ~grant_q) == '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench: packet-level round-robin model feeds an expected-trigger queue.
module tb_uart_tx_arbiter;

  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [NR-1:0]   rq_valid, rq_last, rq_ready, grant;
  logic [8*NR-1:0] rq_data;
  logic            tx_busy, tx_trig, active;
  logic [7:0]      tx_data;

  logic            b_valid, b_last, b_ready, b_grant, b_busy, b_trig, b_active;
  logic [7:0]      b_data, b_dout;

  uart_tx_arbiter #(.NUM_REQ(NR), .HEADER_EN(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(rq_valid), .req_data_in(rq_data), .req_last_in(rq_last),
    .req_ready_out(rq_ready), .tx_busy_in(tx_busy), .tx_trigger_out(tx_trig),
    .tx_data_out(tx_data), .grant_out(grant), .active_out(active)
  );

  uart_tx_arbiter #(.NUM_REQ(1), .HEADER_EN(0)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(b_valid), .req_data_in(b_data), .req_last_in(b_last),
    .req_ready_out(b_ready), .tx_busy_in(b_busy), .tx_trigger_out(b_trig),
    .tx_data_out(b_dout), .grant_out(b_grant), .active_out(b_active)
  );

  typedef struct { logic [7:0] d; logic last; int stall; } item_t;
  typedef struct { logic [7:0] d; int owner; } exp_t;

  item_t drv_q [NR][$];
  item_t mdl_q [NR][$];
  exp_t  exp_q [$];
  int    stall_cnt [NR];

  int total = 0, bad = 0, cyc = 0;
  int busy_len = 20, bcnt = 0, last_fall = 0, m_last = NR - 1, b_trigs = 0;
  bit gap_en = 0, first_in_phase = 1;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d, expected event", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: busy rises the cycle after a trigger and stays high busy_len cycles.
  initial begin
    logic seen;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      seen = tx_trig;
      @(posedge clk);
      #1;
      if (seen) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt > 0);
    end
  end

  // Requester drivers: present queue heads, pop on handshake, honour per-byte stalls.
  initial begin
    logic [NR-1:0] hs;
    rq_valid = '0;
    rq_data  = '0;
    rq_last  = '0;
    for (int r = 0; r < NR; r++) stall_cnt[r] = 0;
    forever begin
      @(negedge clk);
      hs = rq_valid & rq_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (hs[r] && drv_q[r].size() > 0) begin
          void'(drv_q[r].pop_front());
          if (drv_q[r].size() > 0) stall_cnt[r] = drv_q[r][0].stall;
        end
        if (drv_q[r].size() > 0 && stall_cnt[r] == 0) begin
          rq_valid[r]       = 1'b1;
          rq_data[8*r +: 8] = drv_q[r][0].d;
          rq_last[r]        = drv_q[r][0].last;
        end else begin
          rq_valid[r] = 1'b0;
          if (stall_cnt[r] > 0) stall_cnt[r]--;
        end
      end
    end
  end

  // Monitor: every trigger pops one expected byte.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy_prev && !tx_busy) last_fall = cyc;
    busy_prev = tx_busy;
    if (rst_n) begin
      chk("ready_only_owner", longint'(rq_ready & ~grant), 0);
      if (tx_trig) begin
        chk("trig_while_busy", longint'(tx_busy), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trigger: got data 0x%0h, expected no trigger", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", longint'(tx_data), longint'(e.d));
          chk("grant_at_trigger", longint'(grant), longint'(1 << e.owner));
        end
        if (gap_en && !first_in_phase) chk("byte_gap", longint'(cyc - last_fall), 2);
        first_in_phase = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (b_trig) b_trigs++;
  end

  task automatic add_byte(input int r, input logic [7:0] d, input logic last, input int stall);
    drv_q[r].push_back('{d: d, last: last, stall: stall});
    mdl_q[r].push_back('{d: d, last: last, stall: stall});
  endtask

  // Packet-level round robin over requesters that still hold packets.
  task automatic build_expected();
    int    o;
    item_t it;
    first_in_phase = 1;
    forever begin
      o = -1;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (o < 0 && mdl_q[c].size() > 0) o = c;
      end
      if (o < 0) break;
      exp_q.push_back('{d: {4'hA, 4'(o)}, owner: o});
      do begin
        it = mdl_q[o].pop_front();
        exp_q.push_back('{d: it.d, owner: o});
      end while (!it.last);
      m_last = o;
    end
  endtask

  task automatic add_rand_pkt(input int r, input int max_stall);
    int len;
    len = $urandom_range(1, 4);
    for (int b = 0; b < len; b++)
      add_byte(r, 8'($urandom), b == len - 1, (b == 0) ? 0 : $urandom_range(0, max_stall));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || active || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) timeout_fail(name);
    chk({name, "_drained"}, drv_q[0].size() + drv_q[1].size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0; b_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", tx_trig, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ready", rq_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_active", active, 0);
    chk("rst_b_trigger", b_trig, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single packet with header; active drops the cycle after the last busy falls.
    busy_len = 20; gap_en = 1;
    add_byte(0, 8'h12, 1'b0, 0);
    add_byte(0, 8'h34, 1'b1, 0);
    build_expected();
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout_fail("single_pkt_triggers");
    n = 0;
    while (!tx_busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail("single_pkt_busy_rise");
    n = 0;
    while (tx_busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail("single_pkt_busy_fall");
    chk("active_at_busy_fall", active, 1);
    @(negedge clk);
    chk("active_after_last", active, 0);
    chk("grant_after_last", grant, 0);
    wait_idle("single_pkt");

    // Contention: req0 twice, req1 once, all present at once.
    for (int p = 0; p < 2; p++) begin
      add_byte(0, 8'h01 + 8'(p), 1'b0, 0);
      add_byte(0, 8'h11 + 8'(p), 1'b0, 0);
      add_byte(0, 8'h21 + 8'(p), 1'b1, 0);
    end
    add_byte(1, 8'hB1, 1'b0, 0);
    add_byte(1, 8'hB2, 1'b0, 0);
    add_byte(1, 8'hB3, 1'b1, 0);
    build_expected();
    wait_idle("contention");

    // Long busy: no early trigger, gap stays at two cycles.
    busy_len = 50;
    add_byte(0, 8'h5A, 1'b0, 0);
    add_byte(0, 8'hC3, 1'b1, 0);
    build_expected();
    wait_idle("busy_guard");

    // Owner stalls mid-packet; req0 waits without ready.
    busy_len = 20; gap_en = 0;
    add_byte(1, 8'h71, 1'b0, 0);
    add_byte(1, 8'h72, 1'b0, 100);
    add_byte(1, 8'h73, 1'b1, 0);
    add_byte(0, 8'h99, 1'b1, 0);
    build_expected();
    n = 0;
    while (!(grant == 2'b10 && !rq_valid[1]) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout_fail("stall_start");
    repeat (50) @(negedge clk);
    chk("stall_grant", grant, 2'b10);
    chk("stall_ready", rq_ready, 2'b10);
    chk("stall_active", active, 1);
    wait_idle("valid_stall");

    // Random traffic; even phases are stall-free and also check the byte gap.
    for (int p = 0; p < 6; p++) begin
      busy_len = $urandom_range(1, 8);
      gap_en   = (p % 2 == 0);
      for (int r = 0; r < NR; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) add_rand_pkt(r, gap_en ? 0 : 3);
      end
      build_expected();
      wait_idle("random");
    end

    // Reset during WAIT_DONE abandons the packet; requester 0 wins next.
    busy_len = 20; gap_en = 0;
    for (int r = 0; r < NR; r++) begin
      add_byte(r, 8'h40 + 8'(r), 1'b0, 0);
      add_byte(r, 8'h50 + 8'(r), 1'b1, 0);
    end
    build_expected();
    n = 0;
    while (!tx_busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout_fail("reset_busy_rise");
    @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) begin
      drv_q[r].delete();
      mdl_q[r].delete();
      stall_cnt[r] = 0;
    end
    exp_q.delete();
    m_last = NR - 1;
    @(negedge clk);
    chk("rst2_trigger", tx_trig, 0);
    chk("rst2_data", tx_data, 0);
    chk("rst2_ready", rq_ready, 0);
    chk("rst2_grant", grant, 0);
    chk("rst2_active", active, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      add_byte(r, 8'h60 + 8'(r), 1'b0, 0);
      add_byte(r, 8'h70 + 8'(r), 1'b1, 0);
    end
    build_expected();
    wait_idle("post_reset");

    // No-header instance: one-byte packet 8'hFF.
    @(posedge clk); #1;
    b_valid = 1'b1; b_data = 8'hFF; b_last = 1'b1;
    @(negedge clk);
    chk("b_idle_ready", b_ready, 0);
    @(negedge clk);
    chk("b_fetch_ready", b_ready, 1);
    chk("b_grant", b_grant, 1);
    chk("b_active", b_active, 1);
    chk("b_no_early_trigger", b_trig, 0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_trigger", b_trig, 1);
    chk("b_data", b_dout, 8'hFF);
    chk("b_ready_after_hs", b_ready, 0);
    @(posedge clk); #1;
    b_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_active_busy", b_active, 1);
    @(posedge clk); #1;
    b_busy = 1'b0;
    @(negedge clk);
    chk("b_active_at_fall", b_active, 1);
    @(negedge clk);
    chk("b_active_done", b_active, 0);
    chk("b_grant_done", b_grant, 0);
    repeat (5) @(negedge clk);
    chk("b_trigger_count", b_trigs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
